// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: one CSA row per accepted operand keeps a
// redundant sum/carry pair, and a single carry-propagate add resolves each frame.
module csa_stream_accumulator #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_OPS = 4,
    parameter bit          SIGNED  = 1'b0,
    localparam int unsigned OUT_W  = WIDTH + $clog2(MAX_OPS),
    localparam int unsigned CNT_W  = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_result,
    output logic [OUT_W-1:0] out_sum,
    output logic [OUT_W-1:0] out_carry,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_OPS - 1);

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] sum_q, sum_d;
    logic [OUT_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [OUT_W-1:0] x;
    logic [OUT_W-1:0] maj;
    logic             at_max;

    // Upper bits are either zero or copies of the operand sign bit.
    assign x = SIGNED ? {{(OUT_W - WIDTH){in_data[WIDTH-1]}}, in_data}
                      : {{(OUT_W - WIDTH){1'b0}}, in_data};

    assign maj    = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);
    assign at_max = (count_q == LAST_SLOT);

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    sum_d   = sum_q ^ carry_q ^ x;
                    carry_d = {maj[OUT_W-2:0], 1'b0};
                    count_d = count_q + CNT_W'(1);
                    ovf_d   = at_max && !in_last;
                    if (in_last || at_max) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                result_d = sum_q + carry_q;
                valid_d  = 1'b1;
                state_d  = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    sum_d   = '0;
                    carry_d = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACCUM;
            sum_q    <= '0;
            carry_q  <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_sum    = sum_q;
    assign out_carry  = carry_q;
    assign out_count  = count_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: an unsigned and a signed instance share
// the stimulus bus; sel routes in_valid/out_ready to one of them at a time.
module tb_csa_stream_accumulator;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_OPS = 4;
    localparam int unsigned OUT_W   = 10;
    localparam int unsigned CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;

    logic             u_in_ready, s_in_ready, u_out_valid, s_out_valid;
    logic [OUT_W-1:0] u_result, s_result, u_sum, s_sum, u_carry, s_carry;
    logic [CNT_W-1:0] u_count, s_count;
    logic             u_ovf, s_ovf;

    logic             in_ready_m, out_valid_m, ovf_m;
    logic [OUT_W-1:0] result_m, sum_m, carry_m;
    logic [CNT_W-1:0] count_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_stream_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .SIGNED(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid && !sel),
        .in_ready   (u_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (u_out_valid),
        .out_ready  (out_ready && !sel),
        .out_result (u_result),
        .out_sum    (u_sum),
        .out_carry  (u_carry),
        .out_count  (u_count),
        .out_ovf    (u_ovf)
    );

    csa_stream_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .SIGNED(1'b1)) s_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid && sel),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready && sel),
        .out_result (s_result),
        .out_sum    (s_sum),
        .out_carry  (s_carry),
        .out_count  (s_count),
        .out_ovf    (s_ovf)
    );

    assign in_ready_m  = sel ? s_in_ready  : u_in_ready;
    assign out_valid_m = sel ? s_out_valid : u_out_valid;
    assign result_m    = sel ? s_result    : u_result;
    assign sum_m       = sel ? s_sum       : u_sum;
    assign carry_m     = sel ? s_carry     : u_carry;
    assign count_m     = sel ? s_count     : u_count;
    assign ovf_m       = sel ? s_ovf       : u_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready_m && n < 20) begin
            step();
            n++;
        end
        if (!in_ready_m) chk("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [OUT_W-1:0] res,
                              input logic [CNT_W-1:0] cnt, input logic ovf);
        int n = 0;
        while (!out_valid_m && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid_m), 32'd1);
        chk({tag, "_result"}, 32'(result_m), 32'(res));
        chk({tag, "_count"}, 32'(count_m), 32'(cnt));
        chk({tag, "_ovf"}, 32'(ovf_m), 32'(ovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid_m), 32'd0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid_m), 32'd0);
        chk("rst_ready", 32'(in_ready_m), 32'd1);
        chk("rst_result", 32'(result_m), 32'd0);
        chk("rst_count", 32'(count_m), 32'd0);
        chk("rst_sum", 32'(sum_m), 32'd0);
        chk("rst_carry", 32'(carry_m), 32'd0);
        chk("rst_ovf", 32'(ovf_m), 32'd0);

        // 1: small unsigned frame with latency check
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        chk("t1_resolve_valid", 32'(out_valid_m), 32'd0);
        chk("t1_resolve_ready", 32'(in_ready_m), 32'd0);
        step();
        chk("t1_latency_valid", 32'(out_valid_m), 32'd1);
        get_result("t1", 10'h006, 3'd3, 1'b0);

        // 2: redundant pair must already add to the result before RESOLVE
        send(8'hF0, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hAA, 1'b1);
        chk("t2_redundant", 32'(OUT_W'(sum_m + carry_m)), 32'h1A9);
        get_result("t2", 10'h1A9, 3'd3, 1'b0);

        // 3: force-closed frame, then the next operand opens a fresh frame
        for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
        get_result("t3", 10'h3FC, 3'd4, 1'b1);
        send(8'h01, 1'b1);
        get_result("t3_next", 10'h001, 3'd1, 1'b0);

        // 4: signed instance
        sel = 1'b1;
        send(8'hFF, 1'b0);
        send(8'h80, 1'b0);
        send(8'h05, 1'b1);
        get_result("t4a", 10'h384, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h7F, 1'b0);
        get_result("t4b", 10'h1FC, 3'd4, 1'b1);
        sel = 1'b0;

        // 5: output backpressure
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_valid", 32'(out_valid_m), 32'd1);
            chk("t5_hold_result", 32'(result_m), 32'h006);
            chk("t5_hold_ready", 32'(in_ready_m), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_release_valid", 32'(out_valid_m), 32'd0);
        chk("t5_release_ready", 32'(in_ready_m), 32'd1);
        step();
        chk("t5_single_xfer", 32'(out_valid_m), 32'd0);

        // 6: reset mid-frame discards the partial frame
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_sum", 32'(sum_m), 32'd0);
        chk("t6_rst_carry", 32'(carry_m), 32'd0);
        chk("t6_rst_count", 32'(count_m), 32'd0);
        chk("t6_rst_ready", 32'(in_ready_m), 32'd1);
        step();
        step();
        chk("t6_no_valid", 32'(out_valid_m), 32'd0);
        send(8'd4, 1'b0);
        send(8'd4, 1'b1);
        get_result("t6", 10'h008, 3'd2, 1'b0);

        // 6b: reset while a result is being held
        send(8'd1, 1'b0);
        send(8'd2, 1'b1);
        step();
        chk("t6b_valid_before", 32'(out_valid_m), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6b_valid_after", 32'(out_valid_m), 32'd0);
        chk("t6b_result_after", 32'(result_m), 32'd0);
        chk("t6b_ready_after", 32'(in_ready_m), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
